hack_rom_loader: RTL and testbench

Upstream program loader for the Hack CPU. Accepts a byte stream from a serial receiver, assembles big-endian 16-bit words and writes them to the instruction ROM from address 0. It holds the CPU in reset while loading, and releases it only after the last write has completed. It sits between the UART RX and the instruction ROM write port, and drives the CPU reset.

---
 rtl/hack_pkg.sv | 16 +
 rtl/hack_byte2word.sv | 28 ++
 rtl/hack_rom_loader.sv | 185 ++++++++++++++++++
 tb/tb_hack_rom_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU program loader.
package hack_pkg;

    localparam int HACK_WIDTH = 16;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        CNT_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        SUM_HI  = 3'd4,
        SUM_LO  = 3'd5,
        ERROR   = 3'd6
    } loader_state_t;

endpackage

// File: rtl/hack_byte2word.sv
// Big-endian byte pair assembler: the high byte is held, the low byte passes
// straight through so the assembled word is usable in the cycle it arrives.
module hack_byte2word
    import hack_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_data,
    input  logic                  hi_en,
    input  logic                  lo_en,
    output logic [HACK_WIDTH-1:0] word,
    output logic                  word_valid
);

    logic [7:0] hi;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
        end else if (hi_en) begin
            hi <= byte_data;
        end
    end

    assign word       = {hi, byte_data};
    assign word_valid = lo_en;

endmodule

// File: rtl/hack_rom_loader.sv
// Serial program loader for the Hack instruction ROM; holds the CPU in reset
// while loading. Define HACK_LOADER_CHECKSUM_EN to add the trailing checksum check.
//
// state   | meaning
// RUN     | CPU running, next byte is the count high byte
// CNT_LO  | waiting for the count low byte
// DATA_HI | waiting for a word high byte
// DATA_LO | waiting for a word low byte, writes the word
// SUM_HI  | waiting for the checksum high byte
// SUM_LO  | waiting for the checksum low byte, compares
// ERROR   | load failed, CPU held in reset until reset
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ROM_DEPTH = 32768,
    parameter int ADDR_W    = $clog2(ROM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic [HACK_WIDTH-1:0] rom_wdata,
    output logic                  cpu_reset,
    output logic                  loading,
    output logic                  error
);

    // One extra bit so a count equal to ROM_DEPTH does not wrap the index.
    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [31:0] DEPTH_U = 32'(ROM_DEPTH);

    loader_state_t state, state_next;

    logic [CNT_W-1:0]      count, count_next;
    logic [CNT_W-1:0]      idx, idx_next;
    logic                  accept, hi_en, lo_en, word_valid, sum_ok;
    logic [HACK_WIDTH-1:0] word;

    logic                  rom_we_next;
    logic [ADDR_W-1:0]     rom_addr_next;
    logic [HACK_WIDTH-1:0] rom_wdata_next;
    logic                  cpu_reset_next, loading_next, error_next;

`ifdef HACK_LOADER_CHECKSUM_EN
    logic [HACK_WIDTH-1:0] acc, acc_next;
    assign sum_ok = (word == acc);
`else
    assign sum_ok = 1'b1;
`endif

    assign accept = in_valid && in_ready;
    assign hi_en  = accept && (state == RUN || state == DATA_HI || state == SUM_HI);
    assign lo_en  = accept && (state == CNT_LO || state == DATA_LO || state == SUM_LO);

    hack_byte2word u_byte2word (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (in_data),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next     = state;
        count_next     = count;
        idx_next       = idx;
        rom_we_next    = 1'b0;
        rom_addr_next  = rom_addr;
        rom_wdata_next = rom_wdata;
`ifdef HACK_LOADER_CHECKSUM_EN
        acc_next       = acc;
`endif

        case (state)
            RUN: begin
                if (accept) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (word_valid) begin
                    count_next = CNT_W'(word);
                    idx_next   = '0;
`ifdef HACK_LOADER_CHECKSUM_EN
                    acc_next   = '0;
`endif
                    if (32'(word) > DEPTH_U) begin
                        state_next = ERROR;
                    end else if (word == '0) begin
`ifdef HACK_LOADER_CHECKSUM_EN
                        state_next = SUM_HI;
`else
                        state_next = RUN;
`endif
                    end else begin
                        state_next = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) state_next = DATA_LO;
            end
            DATA_LO: begin
                if (word_valid) begin
                    rom_we_next    = 1'b1;
                    rom_addr_next  = idx[ADDR_W-1:0];
                    rom_wdata_next = word;
                    idx_next       = idx + CNT_W'(1);
`ifdef HACK_LOADER_CHECKSUM_EN
                    acc_next       = acc + word;
`endif
                    if (idx_next == count) begin
`ifdef HACK_LOADER_CHECKSUM_EN
                        state_next = SUM_HI;
`else
                        state_next = RUN;
`endif
                    end else begin
                        state_next = DATA_HI;
                    end
                end
            end
            SUM_HI: begin
                if (accept) state_next = SUM_LO;
            end
            SUM_LO: begin
                if (word_valid) state_next = sum_ok ? RUN : ERROR;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        loading_next   = (state_next != RUN) && (state_next != ERROR);
        // Held for one cycle beyond the return to RUN so the last write lands first;
        // !in_ready keeps it high in the first cycle out of reset.
        cpu_reset_next = !in_ready || (state != RUN) || (state_next != RUN);
        error_next     = error || (state_next == ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_reset <= 1'b1;
            loading   <= 1'b0;
            error     <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            count     <= count_next;
            idx       <= idx_next;
            in_ready  <= 1'b1;
            rom_we    <= rom_we_next;
            rom_addr  <= rom_addr_next;
            rom_wdata <= rom_wdata_next;
            cpu_reset <= cpu_reset_next;
            loading   <= loading_next;
            error     <= error_next;
`ifdef HACK_LOADER_CHECKSUM_EN
            acc       <= acc_next;
`endif
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: a full-size instance and a ROM_DEPTH=4 instance.
module tb_hack_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data, in_data4;
    logic        in_valid, in_valid4;

    logic        in_ready, rom_we, cpu_reset, loading, error;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;

    logic        in_ready4, rom_we4, cpu_reset4, loading4, error4;
    logic [1:0]  rom_addr4;
    logic [15:0] rom_wdata4;

    int tests = 0;
    int fails = 0;
    int nwr   = 0;
    int nwr4  = 0;
    int base;

    always #5 clk = ~clk;

    hack_rom_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .loading(loading), .error(error)
    );

    hack_rom_loader #(.ROM_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .rom_we(rom_we4), .rom_addr(rom_addr4), .rom_wdata(rom_wdata4),
        .cpu_reset(cpu_reset4), .loading(loading4), .error(error4)
    );

    always @(posedge clk) begin
        if (rom_we)  nwr++;
        if (rom_we4) nwr4++;
    end

    // Called at a negedge; returns at the next negedge, where T+1 outputs are visible.
    task automatic send(input logic [7:0] b);
        in_data = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        in_data4 = b; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_valid4 = 1'b0; reset = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; in_data = '0; in_data4 = '0;
        @(negedge clk); @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        tests++; if ({rom_we, loading, error} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", {rom_we, loading, error}); end
        tests++; if ({rom_addr, rom_wdata} !== 31'd0) begin fails++; $display("FAIL rst_rom_bus: got %h want 0", {rom_addr, rom_wdata}); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL rel_cpu_reset_hold: got %b want 1", cpu_reset); end
        @(negedge clk);
        tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL rel_cpu_reset_fall: got %b want 0", cpu_reset); end
        repeat (3) @(negedge clk);
        tests++; if (nwr !== 0) begin fails++; $display("FAIL idle_no_writes: got %0d want 0", nwr); end
    endtask

    task automatic test_load_two();
        base = nwr;
        send(8'h00);
        tests++; if ({loading, cpu_reset} !== 2'b11) begin fails++; $display("FAIL load_start: got %b want 11", {loading, cpu_reset}); end
        send(8'h02); send(8'h12); send(8'h34);
        tests++; if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 15'd0, 16'h1234}) begin fails++; $display("FAIL write0: got %b %h %h want 1 0 1234", rom_we, rom_addr, rom_wdata); end
        send(8'hAB);
        tests++; if (rom_we !== 1'b0) begin fails++; $display("FAIL write0_single: got %b want 0", rom_we); end
        send(8'hCD);
        tests++; if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 15'd1, 16'hABCD}) begin fails++; $display("FAIL write1: got %b %h %h want 1 1 abcd", rom_we, rom_addr, rom_wdata); end
`ifdef HACK_LOADER_CHECKSUM_EN
        // 0x1234 + 0xABCD = 0xBE01
        send(8'hBE); send(8'h01);
`endif
        tests++; if ({loading, cpu_reset} !== 2'b01) begin fails++; $display("FAIL load_end: got %b want 01", {loading, cpu_reset}); end
        @(negedge clk);
        tests++; if ({cpu_reset, error} !== 2'b00) begin fails++; $display("FAIL cpu_release: got %b want 00", {cpu_reset, error}); end
        tests++; if (nwr - base !== 2) begin fails++; $display("FAIL load_write_count: got %0d want 2", nwr - base); end
    endtask

`ifdef HACK_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        base = nwr;
        send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'hBE); send(8'h02);
        tests++; if ({error, cpu_reset, loading} !== 3'b110) begin fails++; $display("FAIL sum_mismatch: got %b want 110", {error, cpu_reset, loading}); end
        send(8'h00); send(8'h01); send(8'h11); send(8'h22);
        @(negedge clk);
        tests++; if (nwr - base !== 2) begin fails++; $display("FAIL sum_err_no_writes: got %0d want 2", nwr - base); end
        tests++; if ({error, cpu_reset, in_ready} !== 3'b111) begin fails++; $display("FAIL sum_err_sticky: got %b want 111", {error, cpu_reset, in_ready}); end
        do_reset();
        tests++; if ({error, cpu_reset} !== 2'b00) begin fails++; $display("FAIL sum_err_cleared: got %b want 00", {error, cpu_reset}); end
    endtask
`endif

    task automatic test_oversize_sticky();
        base = nwr;
        send(8'h80); send(8'h01);
        tests++; if ({error, cpu_reset, loading} !== 3'b110) begin fails++; $display("FAIL oversize_err: got %b want 110", {error, cpu_reset, loading}); end
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        @(negedge clk);
        tests++; if (nwr !== base) begin fails++; $display("FAIL err_no_writes: got %0d want %0d", nwr, base); end
        tests++; if ({error, in_ready} !== 2'b11) begin fails++; $display("FAIL err_sticky: got %b want 11", {error, in_ready}); end
        do_reset();
        tests++; if (error !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", error); end
    endtask

    task automatic test_depth4();
        send4(8'h00); send4(8'h04);
        for (int i = 1; i <= 4; i++) begin
            send4(8'h00); send4(8'(i));
        end
        tests++; if ({rom_we4, rom_addr4, rom_wdata4} !== {1'b1, 2'd3, 16'h0004}) begin fails++; $display("FAIL d4_last_write: got %b %h %h want 1 3 0004", rom_we4, rom_addr4, rom_wdata4); end
`ifdef HACK_LOADER_CHECKSUM_EN
        send4(8'h00); send4(8'h0A);
`endif
        tests++; if ({loading4, error4} !== 2'b00) begin fails++; $display("FAIL d4_full_done: got %b want 00", {loading4, error4}); end
        @(negedge clk);
        tests++; if (cpu_reset4 !== 1'b0) begin fails++; $display("FAIL d4_release: got %b want 0", cpu_reset4); end
        tests++; if (nwr4 !== 4) begin fails++; $display("FAIL d4_write_count: got %0d want 4", nwr4); end
        send4(8'h00); send4(8'h05);
        tests++; if ({error4, rom_we4, cpu_reset4} !== 3'b101) begin fails++; $display("FAIL d4_oversize: got %b want 101", {error4, rom_we4, cpu_reset4}); end
        @(negedge clk);
        tests++; if (nwr4 !== 4) begin fails++; $display("FAIL d4_oversize_no_write: got %0d want 4", nwr4); end
        do_reset();
    endtask

    task automatic test_count_zero();
        base = nwr;
        send(8'h00); send(8'h00);
`ifdef HACK_LOADER_CHECKSUM_EN
        send(8'h00); send(8'h00);
`endif
        tests++; if ({loading, cpu_reset, error} !== 3'b010) begin fails++; $display("FAIL zero_end: got %b want 010", {loading, cpu_reset, error}); end
        @(negedge clk);
        tests++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL zero_release: got %b want 0", cpu_reset); end
        tests++; if (nwr !== base) begin fails++; $display("FAIL zero_no_writes: got %0d want %0d", nwr, base); end
    endtask

    task automatic test_midload_reset();
        base = nwr;
        send(8'h00); send(8'h03); send(8'h12); send(8'h34); send(8'hAB);
        do_reset();
        tests++; if (nwr - base !== 1) begin fails++; $display("FAIL mid_writes: got %0d want 1", nwr - base); end
        tests++; if ({loading, cpu_reset, error} !== 3'b000) begin fails++; $display("FAIL mid_run: got %b want 000", {loading, cpu_reset, error}); end
        send(8'h00); send(8'h01); send(8'h55); send(8'h66);
        tests++; if ({rom_we, rom_addr, rom_wdata} !== {1'b1, 15'd0, 16'h5566}) begin fails++; $display("FAIL mid_new_write: got %b %h %h want 1 0 5566", rom_we, rom_addr, rom_wdata); end
`ifdef HACK_LOADER_CHECKSUM_EN
        send(8'h55); send(8'h66);
`endif
        tests++; if (loading !== 1'b0) begin fails++; $display("FAIL mid_new_done: got %b want 0", loading); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_two();
`ifdef HACK_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_oversize_sticky();
        test_depth4();
        test_count_zero();
        test_midload_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
